adder_tree_operand_packer: RTL and testbench

//  Feeds the 5-input binary adder tree. Collects a serial stream of WIDTH-bit operands (valid/ready, in_last marks frame end).

---
 rtl/adder_tree_operand_packer_pkg.sv | 17 +
 rtl/adder_tree_operand_packer_if.sv | 35 +++
 rtl/adder_tree_operand_packer.sv | 109 ++++++++++
 tb/tb_adder_tree_operand_packer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_operand_packer_pkg.sv
// Shared types for the adder tree operand packer: operand count, packer states
// and the slot index type.
package adder_tree_operand_packer_pkg;

  localparam int NUM_OPERANDS = 5;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRESENT = 2'd1,
    DROP    = 2'd2
  } packer_state_t;

  typedef logic [2:0] slot_idx_t;

  localparam slot_idx_t LAST_SLOT = slot_idx_t'(NUM_OPERANDS - 1);

endpackage

// File: rtl/adder_tree_operand_packer_if.sv
// Serial operand stream in, parallel operand frame out. The master side is the
// producer/consumer environment and the slave side is the packer.
interface adder_tree_operand_packer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_c;
  logic [WIDTH-1:0] op_d;
  logic [WIDTH-1:0] op_e;
  logic [2:0]       op_count;
  logic             op_valid;
  logic             op_ready;
  logic [CNT_W-1:0] frame_id;
  logic             err_trunc;

  modport master (
    output in_data, in_valid, in_last, op_ready,
    input  in_ready, op_a, op_b, op_c, op_d, op_e, op_count, op_valid,
           frame_id, err_trunc
  );

  modport slave (
    input  in_data, in_valid, in_last, op_ready,
    output in_ready, op_a, op_b, op_c, op_d, op_e, op_count, op_valid,
           frame_id, err_trunc
  );

endinterface

// File: rtl/adder_tree_operand_packer.sv
// Packs a serial stream of 1..5 operands into zero-padded parallel words for the
// 5-input adder tree, holding each frame until the downstream handshake.
module adder_tree_operand_packer
  import adder_tree_operand_packer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_tree_operand_packer_if.slave bus
);

  packer_state_t    state_q, state_d;
  slot_idx_t        idx_q;
  slot_idx_t        op_count_q;
  logic [WIDTH-1:0] slots_q [NUM_OPERANDS];
  logic [CNT_W-1:0] frame_id_q;
  logic             in_ready_q;
  logic             err_q;
  logic             drop_pending_q;

  logic accept;
  logic close_frame;
  logic overflow;
  logic release_frame;

  // A frame closes on in_last or when the fifth slot fills; a fifth word without
  // in_last means the rest of that source frame must be thrown away.
  always_comb begin
    state_d       = state_q;
    accept        = bus.in_valid && in_ready_q;
    close_frame   = 1'b0;
    overflow      = 1'b0;
    release_frame = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept && (bus.in_last || idx_q == LAST_SLOT)) begin
          close_frame = 1'b1;
          overflow    = !bus.in_last;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.op_ready) begin
          release_frame = 1'b1;
          state_d       = drop_pending_q ? DROP : COLLECT;
        end
      end
      DROP: begin
        if (accept && bus.in_last) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= COLLECT;
      idx_q          <= '0;
      op_count_q     <= '0;
      frame_id_q     <= '0;
      in_ready_q     <= 1'b0;
      err_q          <= 1'b0;
      drop_pending_q <= 1'b0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != PRESENT);
      err_q      <= overflow;
      if (state_q == COLLECT && accept) begin
        slots_q[idx_q] <= bus.in_data;
        idx_q          <= idx_q + 3'd1;
      end
      if (close_frame) begin
        op_count_q <= idx_q + 3'd1;
        frame_id_q <= frame_id_q + 1'b1;
        if (overflow) begin
          drop_pending_q <= 1'b1;
        end
      end
      // Clearing slots on release keeps unused slots at zero for the next frame.
      if (release_frame) begin
        idx_q          <= '0;
        op_count_q     <= '0;
        drop_pending_q <= 1'b0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
          slots_q[i] <= '0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.op_valid  = (state_q == PRESENT);
  assign bus.op_count  = op_count_q;
  assign bus.frame_id  = frame_id_q;
  assign bus.err_trunc = err_q;
  assign bus.op_a      = slots_q[0];
  assign bus.op_b      = slots_q[1];
  assign bus.op_c      = slots_q[2];
  assign bus.op_d      = slots_q[3];
  assign bus.op_e      = slots_q[4];

endmodule

// File: tb/tb_adder_tree_operand_packer.sv
// Directed self-checking bench for the adder tree operand packer.
module tb_adder_tree_operand_packer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [CNT_W-1:0] exp_fid;

  adder_tree_operand_packer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  adder_tree_operand_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Offer one word and wait (bounded) until the packer takes it.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic last);
    int waited;
    bus.in_data  = data;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic handshake();
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.in_data  = 16'd99;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.op_ready = 1'b0;

    // Reset held with a valid word offered
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_op_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("rst_op_a", 32'(bus.op_a), 32'd0);
    checkOutput("rst_op_e", 32'(bus.op_e), 32'd0);
    checkOutput("rst_op_count", 32'(bus.op_count), 32'd0);
    checkOutput("rst_frame_id", 32'(bus.frame_id), 32'd0);
    checkOutput("rst_err", 32'(bus.err_trunc), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

    // Two-word frame
    applyStimulus(16'd10, 1'b0);
    checkOutput("f2_not_yet_valid", 32'(bus.op_valid), 32'd0);
    applyStimulus(16'd20, 1'b1);
    checkOutput("f2_op_valid", 32'(bus.op_valid), 32'd1);
    checkOutput("f2_op_a", 32'(bus.op_a), 32'd10);
    checkOutput("f2_op_b", 32'(bus.op_b), 32'd20);
    checkOutput("f2_op_c", 32'(bus.op_c), 32'd0);
    checkOutput("f2_op_d", 32'(bus.op_d), 32'd0);
    checkOutput("f2_op_e", 32'(bus.op_e), 32'd0);
    checkOutput("f2_op_count", 32'(bus.op_count), 32'd2);
    checkOutput("f2_frame_id", 32'(bus.frame_id), 32'd1);
    checkOutput("f2_in_ready", 32'(bus.in_ready), 32'd0);
    handshake();
    checkOutput("f2_released", 32'(bus.op_valid), 32'd0);
    checkOutput("f2_in_ready_back", 32'(bus.in_ready), 32'd1);

    // Backpressure with an extra word offered while not ready
    applyStimulus(16'd30, 1'b0);
    applyStimulus(16'd40, 1'b0);
    applyStimulus(16'd50, 1'b1);
    bus.in_data  = 16'd777;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_op_valid", 32'(bus.op_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_op_b", 32'(bus.op_b), 32'd40);
    end
    checkOutput("bp_op_a", 32'(bus.op_a), 32'd30);
    checkOutput("bp_op_c", 32'(bus.op_c), 32'd50);
    checkOutput("bp_op_d", 32'(bus.op_d), 32'd0);
    checkOutput("bp_op_count", 32'(bus.op_count), 32'd3);
    checkOutput("bp_frame_id", 32'(bus.frame_id), 32'd2);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    handshake();
    checkOutput("bp_released", 32'(bus.op_valid), 32'd0);
    checkOutput("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_slots_cleared", 32'(bus.op_a), 32'd0);

    // Overflow: seven words, last five-slot frame then drop the rest
    applyStimulus(16'd60, 1'b0);
    applyStimulus(16'd70, 1'b0);
    applyStimulus(16'd80, 1'b0);
    applyStimulus(16'd90, 1'b0);
    applyStimulus(16'd100, 1'b0);
    checkOutput("ov_op_valid", 32'(bus.op_valid), 32'd1);
    checkOutput("ov_op_count", 32'(bus.op_count), 32'd5);
    checkOutput("ov_op_a", 32'(bus.op_a), 32'd60);
    checkOutput("ov_op_d", 32'(bus.op_d), 32'd90);
    checkOutput("ov_op_e", 32'(bus.op_e), 32'd100);
    checkOutput("ov_err_pulse", 32'(bus.err_trunc), 32'd1);
    checkOutput("ov_frame_id", 32'(bus.frame_id), 32'd3);
    tick();
    checkOutput("ov_err_single", 32'(bus.err_trunc), 32'd0);
    handshake();
    checkOutput("ov_drop_in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(16'd110, 1'b0);
    checkOutput("ov_drop_no_valid", 32'(bus.op_valid), 32'd0);
    applyStimulus(16'd120, 1'b1);
    checkOutput("ov_drop_end_no_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("ov_drop_frame_id", 32'(bus.frame_id), 32'd3);
    applyStimulus(16'd5, 1'b1);
    checkOutput("ov_next_valid", 32'(bus.op_valid), 32'd1);
    checkOutput("ov_next_op_a", 32'(bus.op_a), 32'd5);
    checkOutput("ov_next_op_b", 32'(bus.op_b), 32'd0);
    checkOutput("ov_next_count", 32'(bus.op_count), 32'd1);
    checkOutput("ov_next_frame_id", 32'(bus.frame_id), 32'd4);
    handshake();

    // Exactly five words with in_last: no error, no drop
    applyStimulus(16'd1, 1'b0);
    applyStimulus(16'd2, 1'b0);
    applyStimulus(16'd3, 1'b0);
    applyStimulus(16'd4, 1'b0);
    applyStimulus(16'd5, 1'b1);
    checkOutput("f5_count", 32'(bus.op_count), 32'd5);
    checkOutput("f5_op_e", 32'(bus.op_e), 32'd5);
    checkOutput("f5_no_err", 32'(bus.err_trunc), 32'd0);
    handshake();
    applyStimulus(16'd8, 1'b1);
    checkOutput("f5_next_valid", 32'(bus.op_valid), 32'd1);
    checkOutput("f5_next_op_a", 32'(bus.op_a), 32'd8);
    checkOutput("f5_next_frame_id", 32'(bus.frame_id), 32'd6);
    handshake();

    // Reset in the middle of a four-word frame
    applyStimulus(16'd11, 1'b0);
    applyStimulus(16'd12, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_op_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("mid_rst_op_a", 32'(bus.op_a), 32'd0);
    checkOutput("mid_rst_frame_id", 32'(bus.frame_id), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mid_rel_op_valid", 32'(bus.op_valid), 32'd0);
    applyStimulus(16'd7, 1'b1);
    checkOutput("mid_op_a", 32'(bus.op_a), 32'd7);
    checkOutput("mid_op_b", 32'(bus.op_b), 32'd0);
    checkOutput("mid_op_count", 32'(bus.op_count), 32'd1);
    checkOutput("mid_frame_id", 32'(bus.frame_id), 32'd1);
    handshake();

    // frame_id wrap over 256 one-word frames
    exp_fid = 8'd1;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(16'(i), 1'b1);
      exp_fid = exp_fid + 8'd1;
      checkOutput("wrap_frame_id", 32'(bus.frame_id), 32'(exp_fid));
      handshake();
    end
    checkOutput("wrap_final", 32'(bus.frame_id), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
